// File: rtl/sram_bank_pkg.sv
// Shared definitions for the SRAM bank array.
//   - bytes_per_word(): derives the byte-lane count from a word width.
//   - BYTES_PER_WORD: that derivation for the default 32-bit word.
//   - byte_parity(): returns one even-parity bit per byte. Words narrower
//     than PARITY_MAX_WIDTH must be zero-extended before the call.
//   - read_pipe_stage_t: one read-pipeline stage (valid, data, perr) at the
//     default word width.
package sram_bank_pkg;

  localparam int unsigned SRAM_BANK_DATA_WIDTH_DEF = 32'd32;
  localparam int unsigned PARITY_MAX_WIDTH         = 32'd256;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 32'd8;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(SRAM_BANK_DATA_WIDTH_DEF);

  // Even parity: the bit makes each byte plus its parity bit an even count of ones.
  function automatic logic [PARITY_MAX_WIDTH/8-1:0] byte_parity(
    input logic [PARITY_MAX_WIDTH-1:0] word
  );
    logic [PARITY_MAX_WIDTH/8-1:0] par;
    par = '0;
    for (int k = 0; k < int'(PARITY_MAX_WIDTH / 32'd8); k++) begin
      par[k] = ^word[8*k +: 8];
    end
    return par;
  endfunction

  typedef struct packed {
    logic                                valid;
    logic [SRAM_BANK_DATA_WIDTH_DEF-1:0] data;
    logic                                perr;
  } read_pipe_stage_t;

endpackage

// File: rtl/sram_bank_array_if.sv
// Bank-side bus between the AXI SRAM wrapper (master) and the bank array
// (slave). The master drives the shared address, the per-bank chip selects,
// the write enables, the byte enables and the per-column write data. It gets
// back the per-bank read data.
// Optional macro SRAM_BANK_ARRAY_PARITY_EN adds two signals:
//   bank_perr_o   - per-bank parity error flag, aligned with bank_rdata
//   perr_inject_i - when 1 during a write, the stored parity bits are inverted
interface sram_bank_array_if #(
  parameter int unsigned SRAM_BANKS_ROWS      = 32'd1,
  parameter int unsigned SRAM_BANKS_COLS      = 32'd1,
  parameter int unsigned SRAM_BANK_ADDR_WIDTH = 32'd16,
  parameter int unsigned SRAM_BANK_DATA_WIDTH = 32'd32
);
  logic [SRAM_BANK_ADDR_WIDTH-1:0]                                                bank_addr;
  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                                bank_cs;
  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                                bank_we;
  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH/8-1:0]    bank_be;
  logic [SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]                           bank_wdata;
  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]      bank_rdata;
`ifdef SRAM_BANK_ARRAY_PARITY_EN
  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                                bank_perr_o;
  logic                                                                           perr_inject_i;
`endif

  modport master (
    output bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
`ifdef SRAM_BANK_ARRAY_PARITY_EN
    output perr_inject_i,
    input  bank_perr_o,
`endif
    input  bank_rdata
  );

  modport slave (
    input  bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
`ifdef SRAM_BANK_ARRAY_PARITY_EN
    input  perr_inject_i,
    output bank_perr_o,
`endif
    output bank_rdata
  );

endinterface

// File: rtl/sram_bank.sv
// One single-port SRAM bank. It has byte-enabled writes, a multi-cycle read
// pipeline and an output hold register.
// Ports:
//   clk_i, rst_ni - clock and asynchronous active-low reset. The reset clears
//                   the read pipeline and the output, but never the storage.
//   addr          - word address. An address >= DEPTH drops a write, and a
//                   read at that address returns zero.
//   cs, we, be    - chip select, write enable and byte enables.
//   wdata         - write data.
//   rdata         - the most recent completed read. It holds until the next
//                   read completes.
// With SRAM_BANK_ARRAY_PARITY_EN defined the bank also has:
//   perr_inject   - inverts the stored parity bits of a write.
//   perr          - parity error flag for the word in rdata.
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32'd16,
  parameter int unsigned DATA_WIDTH   = 32'd32,
  parameter int unsigned DEPTH        = 32'd1024,
  parameter int unsigned READ_LATENCY = 32'd2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    cs,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef SRAM_BANK_ARRAY_PARITY_EN
  input  logic                    perr_inject,
  output logic                    perr,
`endif
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned BPW      = bytes_per_word(DATA_WIDTH);
  localparam int unsigned IDX_W    = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  localparam int unsigned ADDR_EXT = ADDR_WIDTH + 32'd1;
  localparam int unsigned PIPE_N   = (READ_LATENCY > 32'd1) ? (READ_LATENCY - 32'd1) : 32'd1;
`ifdef SRAM_BANK_ARRAY_PARITY_EN
  localparam int unsigned PKT_W    = DATA_WIDTH + 32'd1;   // {perr, data}
`else
  localparam int unsigned PKT_W    = DATA_WIDTH;
`endif

  // Storage is zero-initialised once at time 0. Reset does not touch it.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: '0};

  logic                  in_range_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [IDX_W-1:0]      idx_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [PKT_W-1:0]      pkt_s;
  logic                  done_s;
  logic [PKT_W-1:0]      done_pkt_s;
  logic [PKT_W-1:0]      out_r;

  // Address range check and access decode. An out-of-range read yields zero.
  always_comb begin
    in_range_s = 1'b0;
    idx_s      = addr[IDX_W-1:0];
    rd_word_s  = '0;
    if ({1'b0, addr} < ADDR_EXT'(DEPTH)) begin
      in_range_s = 1'b1;
      rd_word_s  = mem_r[idx_s];
    end else begin
      in_range_s = 1'b0;
    end
    if (cs && we) begin
      wr_s = in_range_s;
    end else begin
      wr_s = 1'b0;
    end
    if (cs && !we) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  // Byte-enabled write into the data array.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      for (int k = 0; k < int'(BPW); k++) begin
        if (be[k]) begin
          mem_r[idx_s][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

`ifdef SRAM_BANK_ARRAY_PARITY_EN
  logic [BPW-1:0] par_mem_r [DEPTH] = '{default: '0};
  logic [BPW-1:0] wpar_s;
  logic           rd_perr_s;

  // Parity generation for writes. The parity check on reads produces the
  // pipeline packet {perr, data}.
  always_comb begin
    wpar_s    = BPW'(byte_parity(PARITY_MAX_WIDTH'(wdata))) ^ {BPW{perr_inject}};
    rd_perr_s = 1'b0;
    if (in_range_s) begin
      rd_perr_s = |(BPW'(byte_parity(PARITY_MAX_WIDTH'(rd_word_s))) ^ par_mem_r[idx_s]);
    end else begin
      rd_perr_s = 1'b0;
    end
    pkt_s = {rd_perr_s, rd_word_s};
  end

  // Each parity bit is written together with its byte, under the same byte enable.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      for (int k = 0; k < int'(BPW); k++) begin
        if (be[k]) begin
          par_mem_r[idx_s][k] <= wpar_s[k];
        end
      end
    end
  end

  assign perr = out_r[DATA_WIDTH];
`else
  // Without parity the pipeline packet is just the read word.
  always_comb begin
    pkt_s = rd_word_s;
  end
`endif

  // With latency 1 the hold register is the only stage. Longer latencies put
  // L-1 valid-tagged stages in front of it.
  generate
    if (READ_LATENCY <= 32'd1) begin : g_lat1
      assign done_s     = rd_s;
      assign done_pkt_s = pkt_s;
    end else begin : g_pipe
      logic [PIPE_N-1:0] vld_r;
      logic [PKT_W-1:0]  pkt_r [PIPE_N];

      // Read pipeline shift register. Reset discards reads that are in flight.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_r <= '0;
          for (int i = 0; i < int'(PIPE_N); i++) begin
            pkt_r[i] <= '0;
          end
        end else begin
          vld_r[0] <= rd_s;
          pkt_r[0] <= pkt_s;
          for (int i = 1; i < int'(PIPE_N); i++) begin
            vld_r[i] <= vld_r[i-1];
            pkt_r[i] <= pkt_r[i-1];
          end
        end
      end

      assign done_s     = vld_r[PIPE_N-1];
      assign done_pkt_s = pkt_r[PIPE_N-1];
    end
  endgenerate

  // Output hold register. Only a completed read updates it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_r <= '0;
    end else if (done_s) begin
      out_r <= done_pkt_s;
    end else begin
      out_r <= out_r;
    end
  end

  assign rdata = out_r[DATA_WIDTH-1:0];

endmodule

// File: rtl/sram_bank_array.sv
// Array of SRAM_BANKS_ROWS x SRAM_BANKS_COLS independent single-port banks.
// It sits behind the AXI SRAM wrapper. Every bank receives the shared word
// address. Each bank receives the write data of its own column.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset. It clears the read pipelines and
//            the outputs, and keeps the memory contents.
//   bus    - sram_bank_array_if.slave: bank_addr, bank_cs, bank_we, bank_be,
//            bank_wdata in, and bank_rdata out.
// Optional macro SRAM_BANK_ARRAY_PARITY_EN adds per-byte even parity. With it
// defined, the bus also carries bank_perr_o (out) and perr_inject_i (in).
module sram_bank_array
  import sram_bank_pkg::*;
#(
  parameter int unsigned SRAM_BANKS_ROWS      = 32'd1,
  parameter int unsigned SRAM_BANKS_COLS      = 32'd1,
  parameter int unsigned SRAM_BANK_ADDR_WIDTH = 32'd16,
  parameter int unsigned SRAM_BANK_DATA_WIDTH = 32'd32,
  parameter int unsigned SRAM_BANK_DEPTH      = 32'd1024,
  parameter int unsigned SRAM_READ_LATENCY    = 32'd2
) (
  input logic              clk_i,
  input logic              rst_ni,
  sram_bank_array_if.slave bus
);

  generate
    for (genvar r = 0; r < int'(SRAM_BANKS_ROWS); r++) begin : g_row
      for (genvar c = 0; c < int'(SRAM_BANKS_COLS); c++) begin : g_col
        sram_bank #(
          .ADDR_WIDTH   (SRAM_BANK_ADDR_WIDTH),
          .DATA_WIDTH   (SRAM_BANK_DATA_WIDTH),
          .DEPTH        (SRAM_BANK_DEPTH),
          .READ_LATENCY (SRAM_READ_LATENCY)
        ) u_bank (
          .clk_i       (clk_i),
          .rst_ni      (rst_ni),
          .addr        (bus.bank_addr),
          .cs          (bus.bank_cs[r][c]),
          .we          (bus.bank_we[r][c]),
          .be          (bus.bank_be[r][c]),
          .wdata       (bus.bank_wdata[c]),
`ifdef SRAM_BANK_ARRAY_PARITY_EN
          .perr_inject (bus.perr_inject_i),
          .perr        (bus.bank_perr_o[r][c]),
`endif
          .rdata       (bus.bank_rdata[r][c])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_bank_array.sv
// Scoreboard bench for sram_bank_array in a 2x2 array with read latency 2.
// The stimulus keeps a plain array model of every bank's memory. Each read it
// issues pushes the word that read must return, together with the edge at
// which that word reaches the output. A monitor pops each entry when that
// edge arrives and tracks the value every bank output must hold. It compares
// all bank outputs on every cycle.
module tb_sram_bank_array;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int NB    = ROWS * COLS;

  typedef struct {
    int          b;
    int          done;
    logic [31:0] d;
    logic        p;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  sram_bank_array_if #(
    .SRAM_BANKS_ROWS(ROWS), .SRAM_BANKS_COLS(COLS),
    .SRAM_BANK_ADDR_WIDTH(AW), .SRAM_BANK_DATA_WIDTH(DW)
  ) bus ();

  sram_bank_array #(
    .SRAM_BANKS_ROWS(ROWS), .SRAM_BANKS_COLS(COLS),
    .SRAM_BANK_ADDR_WIDTH(AW), .SRAM_BANK_DATA_WIDTH(DW),
    .SRAM_BANK_DEPTH(DEPTH), .SRAM_READ_LATENCY(LAT)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  exp_t        q[$];
  logic [31:0] mdl [NB][DEPTH];
  logic [3:0]  bad [NB][DEPTH];
  logic [31:0] exp_hold [NB];
  logic        exp_perr [NB];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: retire completed reads into the expected hold values, then compare.
  always @(posedge clk_i) begin
    if (mon_en) begin
      #1;
      while (q.size() > 0 && q[0].done <= cyc) begin
        exp_t e;
        e = q.pop_front();
        exp_hold[e.b] = e.d;
        exp_perr[e.b] = e.p;
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          chk($sformatf("rdata[%0d][%0d]", r, c), bus.bank_rdata[r][c], exp_hold[r*COLS+c]);
`ifdef SRAM_BANK_ARRAY_PARITY_EN
          chk($sformatf("perr[%0d][%0d]", r, c), 32'(bus.bank_perr_o[r][c]), 32'(exp_perr[r*COLS+c]));
`endif
        end
      end
    end
  end

  // Drive one cycle of bank accesses and update the reference model.
  task automatic step(input logic [NB-1:0] cs, input logic [NB-1:0] we,
                      input logic [AW-1:0] addr, input logic [NB*4-1:0] be,
                      input logic [COLS*DW-1:0] wd, input logic inj);
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.bank_cs[r][c] = cs[r*COLS+c];
        bus.bank_we[r][c] = we[r*COLS+c];
        bus.bank_be[r][c] = be[(r*COLS+c)*4 +: 4];
      end
    end
    for (int c = 0; c < COLS; c++) bus.bank_wdata[c] = wd[c*DW +: DW];
    bus.bank_addr = addr;
`ifdef SRAM_BANK_ARRAY_PARITY_EN
    bus.perr_inject_i = inj;
`endif
    for (int b = 0; b < NB; b++) begin
      if (cs[b] && we[b]) begin
        if (int'(addr) < DEPTH) begin
          for (int k = 0; k < 4; k++) begin
            if (be[b*4+k]) begin
              mdl[b][addr][8*k +: 8] = wd[(b % COLS)*DW + 8*k +: 8];
              bad[b][addr][k] = inj;
            end
          end
        end
      end else if (cs[b]) begin
        e.b    = b;
        e.done = cyc + LAT;
        if (int'(addr) < DEPTH) begin
          e.d = mdl[b][addr];
          e.p = |bad[b][addr];
        end else begin
          e.d = 32'h0;
          e.p = 1'b0;
        end
        q.push_back(e);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, '0, '0, 1'b0);
  endtask

  // One-cycle reset. Reads still in flight are discarded, and the memory is kept.
  task automatic do_reset();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.bank_cs[r][c] = 1'b0;
        bus.bank_we[r][c] = 1'b0;
      end
    end
    rst_ni = 1'b0;
    q.delete();
    for (int b = 0; b < NB; b++) begin
      exp_hold[b] = 32'h0;
      exp_perr[b] = 1'b0;
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      exp_hold[b] = 32'h0;
      exp_perr[b] = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        mdl[b][a] = 32'h0;
        bad[b][a] = 4'h0;
      end
    end
    bus.bank_addr  = '0;
    bus.bank_cs    = '0;
    bus.bank_we    = '0;
    bus.bank_be    = '0;
    bus.bank_wdata = '0;
`ifdef SRAM_BANK_ARRAY_PARITY_EN
    bus.perr_inject_i = 1'b0;
`endif
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Full write of 0xDEADBEEF, then read back.
    step(4'b0001, 4'b0001, 16'd5, 16'h000F, {32'h0, 32'hDEADBEEF}, 1'b0);
    step(4'b0001, 4'b0000, 16'd5, 16'h0000, '0, 1'b0);
    idle(3);
    // Partial write with be=0101 over the same word. The read returns 0xDE22BE44.
    step(4'b0001, 4'b0001, 16'd5, 16'h0005, {32'h0, 32'h11223344}, 1'b0);
    step(4'b0001, 4'b0000, 16'd5, 16'h0000, '0, 1'b0);
    idle(3);

    // Back-to-back reads, then a hold over 10 idle cycles.
    for (int i = 1; i <= 3; i++) step(4'b0001, 4'b0001, 16'(i), 16'h000F, {32'h0, 32'(i * 256)}, 1'b0);
    for (int i = 1; i <= 3; i++) step(4'b0001, 4'b0000, 16'(i), 16'h0000, '0, 1'b0);
    idle(10);

    // Chip-select isolation: only bank [1][0] is written at address 7.
    step(4'b1111, 4'b1111, 16'd7, 16'hFFFF, {32'h7777_0001, 32'h7777_0000}, 1'b0);
    step(4'b0100, 4'b0100, 16'd7, 16'hFFFF, {32'h1234_5678, 32'hA5A5A5A5}, 1'b0);
    step(4'b1111, 4'b0000, 16'd7, 16'h0000, '0, 1'b0);
    idle(3);

    // Reset while a read is in flight, then read the same address again.
    step(4'b0001, 4'b0000, 16'd5, 16'h0000, '0, 1'b0);
    do_reset();
    idle(3);
    step(4'b0001, 4'b0000, 16'd5, 16'h0000, '0, 1'b0);
    idle(3);

    // Out-of-range: the write is dropped and the read returns zero.
    step(4'b1111, 4'b1111, 16'd1024, 16'hFFFF, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b0);
    step(4'b1111, 4'b0000, 16'd1024, 16'h0000, '0, 1'b0);
    step(4'b1111, 4'b0000, 16'hFFFF, 16'h0000, '0, 1'b0);
    idle(3);

`ifdef SRAM_BANK_ARRAY_PARITY_EN
    // Injected parity error, then a clean rewrite.
    step(4'b0001, 4'b0001, 16'd9, 16'h000F, {32'h0, 32'h0F0F_0101}, 1'b1);
    step(4'b0001, 4'b0000, 16'd9, 16'h0000, '0, 1'b0);
    idle(3);
    step(4'b0001, 4'b0001, 16'd9, 16'h000F, {32'h0, 32'h0F0F_0101}, 1'b0);
    step(4'b0001, 4'b0000, 16'd9, 16'h0000, '0, 1'b0);
    step(4'b0001, 4'b0000, 16'd2000, 16'h0000, '0, 1'b0);
    idle(3);
`endif

    // Random traffic over a small address window, with some out-of-range
    // accesses and an occasional reset.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 9) == 0) a = 16'(1024 + $urandom_range(0, 100));
      else a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(4'($urandom), 4'($urandom), a, 16'($urandom), {$urandom, $urandom},
             ($urandom_range(0, 3) == 0));
      end
    end

    idle(LAT + 3);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
